// File: rtl/gate_fault_pkg.sv
// gate_fault_pkg
// Constants and types shared by the gate-level fault-simulation cells.
// The diag codes are bit-oriented:
//   bit 0 = "output low while input low" evidence (Z Sa0 or A Sa1)
//   bit 1 = "output high while input high" evidence (Z Sa1 or A Sa0)
// A cell therefore builds its sticky code by OR-ing the two evidence bits.
// When both pieces of evidence are present the result is DIAG_MULTI.
package gate_fault_pkg;

    typedef logic [1:0] diag_t;

    localparam diag_t DIAG_OK    = 2'd0;
    localparam diag_t DIAG_Z0_A1 = 2'd1;
    localparam diag_t DIAG_Z1_A0 = 2'd2;
    localparam diag_t DIAG_MULTI = 2'd3;

    localparam logic SITE_A = 1'b0;
    localparam logic SITE_Z = 1'b1;

endpackage

// File: rtl/one_input_not_if.sv
// one_input_not_if
// Bundles the data, fault-injection, checker-control and checker-status
// signals of a one-input gate cell. clk and rst_n stay as plain ports.
//   master : drives A, fault_en/site/val, chk_en/chk_clr.
//            Observes Z, mismatch, diag, sample_cnt and err_cnt.
//   slave  : the gate cell (directions reversed).
interface one_input_not_if #(
    parameter int CNT_W = 8
);
    logic                  A;
    logic                  Z;
    logic                  fault_en;
    logic                  fault_site;
    logic                  fault_val;
    logic                  chk_en;
    logic                  chk_clr;
    logic                  mismatch;
    gate_fault_pkg::diag_t diag;
    logic [CNT_W-1:0]      sample_cnt;
    logic [CNT_W-1:0]      err_cnt;

    modport master (
        output A, fault_en, fault_site, fault_val, chk_en, chk_clr,
        input  Z, mismatch, diag, sample_cnt, err_cnt
    );

    modport slave (
        input  A, fault_en, fault_site, fault_val, chk_en, chk_clr,
        output Z, mismatch, diag, sample_cnt, err_cnt
    );
endinterface

// File: rtl/one_input_not_fault_checker.sv
// fault_checker
// Online checker for a one-input inverting cell. It compares the observed
// output against the ideal ~A, keeps a sticky diagnosis code, and counts
// sampled cycles and mismatches with saturating counters.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset.
//   a           raw input pin (never faulted).
//   z           observed (possibly faulted) output.
//   chk_en      sample this cycle.
//   chk_clr     synchronous clear. It has priority over chk_en.
//   mismatch    registered: last sampled z differed from ~a.
//   diag        sticky diagnosis code (gate_fault_pkg DIAG_*).
//   sample_cnt  saturating count of sampled cycles.
//   err_cnt     saturating count of sampled mismatches.
import gate_fault_pkg::*;

module fault_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             z,
    input  logic             chk_en,
    input  logic             chk_clr,
    output logic             mismatch,
    output diag_t            diag,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic  z_ideal;
    logic  miss;
    diag_t evidence;

    always_comb begin
        z_ideal  = ~a;
        miss     = (z != z_ideal);
        evidence = DIAG_OK;
        // Output equal to input is impossible for a healthy inverter.
        // The polarity of that equality says which way the fault pulls.
        if (!a && !z) evidence = evidence | DIAG_Z0_A1;
        if (a && z)   evidence = evidence | DIAG_Z1_A0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch   <= 1'b0;
            diag       <= DIAG_OK;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (chk_clr) begin
            mismatch   <= 1'b0;
            diag       <= DIAG_OK;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (chk_en) begin
            mismatch   <= miss;
            diag       <= diag | evidence;
            sample_cnt <= sat_inc(sample_cnt);
            if (miss) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: rtl/one_input_not.sv
// one_input_not
// Single-bit inverter (Z = ~A) with stuck-at fault injection on net A or
// net Z, and an online fault_checker that diagnoses the injected fault.
// The data path is purely combinational and is not affected by reset.
// Ports:
//   clk    clock for the checker.
//   rst_n  asynchronous active-low reset of the checker state.
//   bus    one_input_not_if.slave: A, Z, fault_en/site/val,
//          chk_en/chk_clr, mismatch, diag, sample_cnt, err_cnt.
import gate_fault_pkg::*;

module one_input_not #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    one_input_not_if.slave bus
);

    logic             a_eff;
    logic             z_int;
    logic             mismatch;
    diag_t            diag;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;

    // The injection muxes sit either side of the inverter. A stuck A is
    // therefore seen inverted at Z, while a stuck Z appears at Z directly.
    always_comb begin
        a_eff = bus.A;
        if (bus.fault_en && bus.fault_site == SITE_A) a_eff = bus.fault_val;
        z_int = ~a_eff;
        if (bus.fault_en && bus.fault_site == SITE_Z) z_int = bus.fault_val;
    end

    assign bus.Z = z_int;

    // The checker takes the raw pin A, so its reference is never faulted.
    fault_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (bus.A),
        .z          (z_int),
        .chk_en     (bus.chk_en),
        .chk_clr    (bus.chk_clr),
        .mismatch   (mismatch),
        .diag       (diag),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    assign bus.mismatch   = mismatch;
    assign bus.diag       = diag;
    assign bus.sample_cnt = sample_cnt;
    assign bus.err_cnt    = err_cnt;

endmodule

// File: tb/tb_one_input_not.sv
// tb_one_input_not
// Directed bench for one_input_not. Each sampling/clearing cycle pushes its
// hand-computed post-edge state into a queue. A monitor process pops and
// compares whenever the DUT takes a sample or clear. A second instance with
// CNT_W=2 covers counter saturation.
module tb_one_input_not;

    logic clk;
    logic rst_n;

    one_input_not_if #(.CNT_W(8)) bus ();
    one_input_not_if #(.CNT_W(2)) bus2 ();

    one_input_not #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    one_input_not #(.CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       z;
        logic       mm;
        logic [1:0] diag;
        logic [7:0] scnt;
        logic [7:0] ecnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and record the expected registered state.
    task automatic issue(input logic a, input logic fe, input logic fs, input logic fv,
                         input logic en, input logic clr,
                         input logic ez, input logic emm, input logic [1:0] ed,
                         input logic [7:0] es, input logic [7:0] ee);
        exp_t e;
        @(negedge clk);
        bus.A = a; bus.fault_en = fe; bus.fault_site = fs; bus.fault_val = fv;
        bus.chk_en = en; bus.chk_clr = clr;
        #1;
        check("z_comb", {31'd0, bus.Z}, {31'd0, ez});
        if (en || clr) begin
            e.z = ez; e.mm = emm; e.diag = ed; e.scnt = es; e.ecnt = ee;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.chk_en = 1'b0; bus.chk_clr = 1'b0; bus.fault_en = 1'b0;
    endtask

    // Monitor: a sampling or clearing edge is the DUT's "output valid".
    always @(posedge clk) begin
        logic z_at;
        exp_t e;
        if (rst_n && (bus.chk_en || bus.chk_clr)) begin
            z_at = bus.Z;
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("z_at_edge", {31'd0, z_at}, {31'd0, e.z});
                check("mismatch", {31'd0, bus.mismatch}, {31'd0, e.mm});
                check("diag", {30'd0, bus.diag}, {30'd0, e.diag});
                check("sample_cnt", {24'd0, bus.sample_cnt}, {24'd0, e.scnt});
                check("err_cnt", {24'd0, bus.err_cnt}, {24'd0, e.ecnt});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.A = 1'b0; bus.fault_en = 1'b0; bus.fault_site = 1'b0; bus.fault_val = 1'b0;
        bus.chk_en = 1'b0; bus.chk_clr = 1'b0;
        bus2.A = 1'b0; bus2.fault_en = 1'b0; bus2.fault_site = 1'b0; bus2.fault_val = 1'b0;
        bus2.chk_en = 1'b0; bus2.chk_clr = 1'b0;

        // Reset state
        #3;
        check("rst_mismatch", {31'd0, bus.mismatch}, 32'd0);
        check("rst_diag", {30'd0, bus.diag}, 32'd0);
        check("rst_sample_cnt", {24'd0, bus.sample_cnt}, 32'd0);
        check("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // No fault: A=0 -> Z=1, A=1 -> Z=0
        //    args: a  fe fs fv en clr  z  mm diag s  e
        issue(1'b0, 0, 0, 0, 1, 0, 1'b1, 0, 2'd0, 8'd1, 8'd0);
        issue(1'b1, 0, 0, 0, 1, 0, 1'b0, 0, 2'd0, 8'd2, 8'd0);
        issue(1'b1, 0, 0, 0, 1, 1, 1'b0, 0, 2'd0, 8'd0, 8'd0);

        // A stuck at 1
        issue(1'b0, 1, 0, 1, 1, 0, 1'b0, 1, 2'd1, 8'd1, 8'd1);
        issue(1'b1, 1, 0, 1, 1, 0, 1'b0, 0, 2'd1, 8'd2, 8'd1);
        issue(1'b1, 0, 0, 0, 0, 1, 1'b0, 0, 2'd0, 8'd0, 8'd0);

        // Z stuck at 1
        issue(1'b0, 1, 1, 1, 1, 0, 1'b1, 0, 2'd0, 8'd1, 8'd0);
        issue(1'b1, 1, 1, 1, 1, 0, 1'b1, 1, 2'd2, 8'd2, 8'd1);

        // chk_en=0 with a fault that would mismatch: everything holds
        issue(1'b0, 1, 1, 1, 0, 0, 1'b1, 0, 2'd0, 8'd0, 8'd0);
        @(negedge clk);
        check("hold_mismatch", {31'd0, bus.mismatch}, 32'd1);
        check("hold_diag", {30'd0, bus.diag}, 32'd2);
        check("hold_sample_cnt", {24'd0, bus.sample_cnt}, 32'd2);
        check("hold_err_cnt", {24'd0, bus.err_cnt}, 32'd1);

        // Asynchronous reset mid-run, away from any clock edge
        bus.fault_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_mismatch", {31'd0, bus.mismatch}, 32'd0);
        check("arst_diag", {30'd0, bus.diag}, 32'd0);
        check("arst_sample_cnt", {24'd0, bus.sample_cnt}, 32'd0);
        check("arst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        bus.A = 1'b1; #1;
        check("arst_z_a1", {31'd0, bus.Z}, 32'd0);
        bus.A = 1'b0; #1;
        check("arst_z_a0", {31'd0, bus.Z}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Z Sa0 then Z Sa1: sticky OR gives DIAG_MULTI
        issue(1'b0, 1, 1, 0, 1, 0, 1'b0, 1, 2'd1, 8'd1, 8'd1);
        issue(1'b1, 1, 1, 1, 1, 0, 1'b1, 1, 2'd3, 8'd2, 8'd2);
        // Clear beats a simultaneous mismatching sample
        issue(1'b0, 1, 1, 0, 1, 1, 1'b0, 0, 2'd0, 8'd0, 8'd0);
        idle();

        // Saturation on the CNT_W=2 instance: Z Sa1 with A=1, 5 samples
        @(negedge clk);
        bus2.A = 1'b1; bus2.fault_en = 1'b1; bus2.fault_site = 1'b1; bus2.fault_val = 1'b1;
        bus2.chk_en = 1'b1;
        repeat (5) @(negedge clk);
        bus2.chk_en = 1'b0;
        check("sat_sample_cnt", {30'd0, bus2.sample_cnt}, 32'd3);
        check("sat_err_cnt", {30'd0, bus2.err_cnt}, 32'd3);
        check("sat_mismatch", {31'd0, bus2.mismatch}, 32'd1);
        check("sat_diag", {30'd0, bus2.diag}, 32'd2);

        // Bounded drain of the scoreboard
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within 20000 time units");
        $fatal(1);
    end

endmodule
